// File: rtl/gshare_branch_predictor.sv
// Fetch-stage gshare/bimodal direction predictor with tagged BTB; lookup is combinational, training from EX.
// Latency 0 on lookup; no backpressure, with Ready low while the clear walk rewrites every entry.
module gshare_branch_predictor #(
    parameter int IDX_BITS = 5,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 5,
    parameter int TAG_BITS = 8
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                ClearTables,
    input  logic [31:0]         LookupPC,
    output logic                PredTaken,
    output logic [31:0]         PredTarget,
    output logic [IDX_BITS-1:0] LookupIdx,
    output logic                Ready,
    input  logic                UpdateValid,
    input  logic [IDX_BITS-1:0] UpdateIdx,
    input  logic [31:0]         UpdatePC,
    input  logic                UpdateTaken,
    input  logic [31:0]         UpdateTarget,
    input  logic                UpdateMispred,
    output logic [15:0]         MispredCount
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [IDX_BITS-1:0] WP_LAST  = IDX_BITS'(ENTRIES - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IDX_BITS-1:0] wp;
    logic [GW-1:0]       ghr;
    logic [15:0]         mcount;

    logic [CTR_BITS-1:0] ctr       [ENTRIES];
    logic                btb_valid [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag   [ENTRIES];
    logic [29:0]         btb_tgt   [ENTRIES];

    logic                do_update;
    logic                do_clear;
    logic [IDX_BITS-1:0] ghr_ext;
    logic [IDX_BITS-1:0] lk_bidx;
    logic [IDX_BITS-1:0] lk_pidx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic [IDX_BITS-1:0] up_bidx;
    logic [TAG_BITS-1:0] up_tag;
    logic [31:0]         seq_pc;
    logic                unused_bits;

    assign Ready     = (state == S_RUN);
    assign do_clear  = Ready && ClearTables;
    // A clear in the same cycle as a resolved branch discards the training.
    assign do_update = Ready && !ClearTables && UpdateValid;

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:  if (wp == WP_LAST) state_nx = S_RUN;
            S_RUN:   if (ClearTables)   state_nx = S_INIT;
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= S_INIT;
            wp     <= '0;
            ghr    <= '0;
            mcount <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT) begin
                wp <= wp + 1'b1;
            end else if (do_clear) begin
                wp <= '0;
            end
            if (do_clear) begin
                ghr <= '0;
            end else if (do_update && (GHR_BITS > 0)) begin
                ghr <= GW'({ghr, UpdateTaken});
            end
            if (do_update && UpdateMispred && (mcount != 16'hFFFF)) begin
                mcount <= mcount + 16'd1;
            end
        end
    end

    assign up_bidx = UpdatePC[IDX_BITS+1:2];
    assign up_tag  = UpdatePC[TAG_HI:TAG_LO];

    // Tables carry no reset; the walk rewrites every entry before Ready rises.
    always_ff @(negedge CLK) begin
        if (state == S_INIT) begin
            ctr[wp]       <= CTR_WEAK;
            btb_valid[wp] <= 1'b0;
        end else if (do_update) begin
            if (UpdateTaken) begin
                if (ctr[UpdateIdx] != CTR_MAX) begin
                    ctr[UpdateIdx] <= ctr[UpdateIdx] + 1'b1;
                end
                btb_valid[up_bidx] <= 1'b1;
                btb_tag[up_bidx]   <= up_tag;
                btb_tgt[up_bidx]   <= UpdateTarget[31:2];
            end else if (ctr[UpdateIdx] != '0) begin
                ctr[UpdateIdx] <= ctr[UpdateIdx] - 1'b1;
            end
        end
    end

    generate
        if (GHR_BITS > 0) begin : g_gshare
            assign ghr_ext = IDX_BITS'(ghr);
        end else begin : g_bimodal
            assign ghr_ext = '0;
        end
    endgenerate

    assign lk_bidx   = LookupPC[IDX_BITS+1:2];
    assign lk_tag    = LookupPC[TAG_HI:TAG_LO];
    assign lk_pidx   = lk_bidx ^ ghr_ext;
    assign lk_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
    assign seq_pc    = LookupPC + 32'd4;

    assign LookupIdx    = lk_pidx;
    assign PredTaken    = Ready && lk_hit && ctr[lk_pidx][CTR_BITS-1];
    assign PredTarget   = PredTaken ? {btb_tgt[lk_bidx], 2'b00} : {seq_pc[31:2], 2'b00};
    assign MispredCount = mcount;

    assign unused_bits = ^{LookupPC[1:0], LookupPC[31:TAG_HI+1], UpdatePC[1:0],
                           UpdatePC[31:TAG_HI+1], UpdateTarget[1:0], seq_pc[1:0], ghr};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomised and directed bench for gshare_branch_predictor, checked against a table-level reference model.
module tb_gshare_branch_predictor;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ClearTables;
    logic [31:0] LookupPC;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic [4:0]  LookupIdx;
    logic        Ready;
    logic        UpdateValid;
    logic [4:0]  UpdateIdx;
    logic [31:0] UpdatePC;
    logic        UpdateTaken;
    logic [31:0] UpdateTarget;
    logic        UpdateMispred;
    logic [15:0] MispredCount;

    gshare_branch_predictor #(
        .IDX_BITS(5), .CTR_BITS(2), .GHR_BITS(5), .TAG_BITS(8)
    ) dut (
        .CLK(CLK), .Reset(Reset), .ClearTables(ClearTables), .LookupPC(LookupPC),
        .PredTaken(PredTaken), .PredTarget(PredTarget), .LookupIdx(LookupIdx), .Ready(Ready),
        .UpdateValid(UpdateValid), .UpdateIdx(UpdateIdx), .UpdatePC(UpdatePC),
        .UpdateTaken(UpdateTaken), .UpdateTarget(UpdateTarget), .UpdateMispred(UpdateMispred),
        .MispredCount(MispredCount)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain arrays of counter values and BTB entries.
    int unsigned m_ctr [32];
    bit          m_bv  [32];
    int unsigned m_tag [32];
    logic [31:0] m_tgt [32];
    int unsigned m_ghr;
    int unsigned m_walk;
    int unsigned m_mc;

    typedef struct packed {
        logic        taken;
        logic [31:0] tgt;
        logic [4:0]  idx;
        logic        rdy;
        logic [15:0] mc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_ctr[i] = 1;
            m_bv[i]  = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        model_clear();
        m_ghr  = 0;
        m_walk = 32;
        m_mc   = 0;
    endfunction

    function automatic exp_t predict(input logic [31:0] pc);
        exp_t e;
        int unsigned b, p, t;
        b = (pc / 4) % 32;
        t = (pc / 128) % 256;
        p = b ^ m_ghr;
        e.rdy   = (m_walk == 0);
        e.taken = e.rdy && m_bv[b] && (m_tag[b] == t) && (m_ctr[p] >= 2);
        e.tgt   = e.taken ? m_tgt[b] : pc + 32'd4;
        e.idx   = p[4:0];
        e.mc    = m_mc[15:0];
        return e;
    endfunction

    function automatic void model_edge();
        int unsigned u, b;
        if (Reset) return;
        if (m_walk > 0) begin
            m_walk--;
        end else if (ClearTables) begin
            model_clear();
            m_ghr  = 0;
            m_walk = 32;
        end else if (UpdateValid) begin
            u = 32'(UpdateIdx);
            if (UpdateTaken) begin
                if (m_ctr[u] < 3) m_ctr[u]++;
                b        = (UpdatePC / 4) % 32;
                m_bv[b]  = 1'b1;
                m_tag[b] = (UpdatePC / 128) % 256;
                m_tgt[b] = UpdateTarget & 32'hFFFF_FFFC;
            end else if (m_ctr[u] > 0) begin
                m_ctr[u]--;
            end
            m_ghr = (m_ghr * 2 + (UpdateTaken ? 1 : 0)) % 32;
            if (UpdateMispred && m_mc < 65535) m_mc++;
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 63)) * 32'd4;
    endfunction

    function automatic logic [31:0] pc_for(input int unsigned idx);
        return 32'((idx ^ m_ghr) % 32) * 32'd4;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [4:0] uidx,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic um, input logic clr);
        LookupPC      = pc;
        UpdateValid   = uv;
        UpdateIdx     = uidx;
        UpdatePC      = upc;
        UpdateTaken   = ut;
        UpdateTarget  = utgt;
        UpdateMispred = um;
        ClearTables   = clr;
        exp_q.push_back(predict(pc));
    endtask

    task automatic tick();
        @(negedge CLK);
        model_edge();
        #1;
    endtask

    task automatic step(input logic [31:0] pc, input logic uv, input logic [4:0] uidx,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic um, input logic clr);
        drive(pc, uv, uidx, upc, ut, utgt, um, clr);
        tick();
    endtask

    task automatic drive_rand(input logic clr);
        drive(rand_pc(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_pc(),
              1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), clr);
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic et, input logic [31:0] etgt);
        drive(pc, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        check({nm, "_taken"}, 32'(PredTaken), 32'(et));
        check({nm, "_target"}, PredTarget, etgt);
        tick();
    endtask

    task automatic count_walk(input string nm);
        int n = 0;
        while (Ready !== 1'b1 && n < 100) begin
            drive_rand(1'b0);
            #2;
            check({nm, "_pred_off"}, 32'(PredTaken), 32'd0);
            tick();
            n++;
        end
        check({nm, "_edges"}, n, 32);
    endtask

    // Scoreboard monitor: pops one expectation per cycle at the rising edge, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_taken", 32'(PredTaken), 32'(e.taken));
                check("sb_target", PredTarget, e.tgt);
                check("sb_idx", 32'(LookupIdx), 32'(e.idx));
                check("sb_ready", 32'(Ready), 32'(e.rdy));
                check("sb_mcount", 32'(MispredCount), 32'(e.mc));
            end
        end
    end

    initial begin
        int unsigned u, mc_before;
        Reset = 1'b1;
        ClearTables = 1'b0; LookupPC = '0; UpdateValid = 1'b0; UpdateIdx = '0;
        UpdatePC = '0; UpdateTaken = 1'b0; UpdateTarget = '0; UpdateMispred = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;

        drive(32'h1234_5670, 1'b1, 5'd3, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        #2;
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_taken", 32'(PredTaken), 32'd0);
        check("rst_target", PredTarget, 32'h1234_5674);
        check("rst_mcount", 32'(MispredCount), 32'd0);
        tick();
        Reset = 1'b0;
        count_walk("t1_walk");

        // Reset in the middle of the walk restarts it from entry 0.
        Reset = 1'b1; model_reset();
        step(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        Reset = 1'b0;
        repeat (10) begin drive_rand(1'b0); tick(); end
        Reset = 1'b1; model_reset();
        drive_rand(1'b0);
        #2;
        check("midwalk_rst_ready", 32'(Ready), 32'd0);
        tick(); tick();
        Reset = 1'b0;
        count_walk("t5_rst_walk");

        for (int i = 0; i < 32; i++)
            step(rand_pc(), 1'b1, 5'(i), 32'(i) * 32'd4, 1'b1, 32'h1000 + 32'(i) * 32'd16, 1'b0, 1'b0);

        u = ((32'h40 / 4) ^ m_ghr) % 32;
        repeat (2) step(32'h0, 1'b1, 5'(u), 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        look("t2_trained", 32'h40, 1'b1, 32'h100);

        step(32'h0, 1'b1, 5'd5, 32'hC0, 1'b1, 32'h500, 1'b0, 1'b0);
        look("t4_alias_miss", 32'h40, 1'b0, 32'h44);
        look("t4_alias_hit", 32'hC0, 1'b1, 32'h500);

        repeat (5) step(32'h0, 1'b1, 5'd7, 32'hC0, 1'b1, 32'h500, 1'b0, 1'b0);
        step(32'h0, 1'b1, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        look("t3_sat_top", pc_for(7), 1'b1, 32'h1000 + ((32'd7 ^ m_ghr) % 32) * 32'd16);
        repeat (5) step(32'h0, 1'b1, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b1, 5'd7, 32'hC0, 1'b1, 32'h500, 1'b0, 1'b0);
        look("t3_sat_floor", pc_for(7), 1'b0, pc_for(7) + 32'd4);
        step(32'h0, 1'b1, 5'd7, 32'hC0, 1'b1, 32'h500, 1'b0, 1'b0);
        look("t3_recover", pc_for(7), 1'b1, 32'h1000 + ((32'd7 ^ m_ghr) % 32) * 32'd16);

        repeat (3000) begin
            drive_rand(1'($urandom_range(0, 299) == 0));
            tick();
        end

        for (int i = 0; i < 40 && m_walk != 0; i++) begin drive_rand(1'b0); tick(); end
        mc_before = m_mc;
        step(32'h40, 1'b1, 5'd1, 32'h40, 1'b1, 32'h900, 1'b1, 1'b1);
        count_walk("t5_clear_walk");
        check("t5_mcount_kept", 32'(MispredCount), mc_before);

        Reset = 1'b1; model_reset();
        step(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        Reset = 1'b0;
        count_walk("t6_walk");
        for (int i = 1; i <= 65540; i++) begin
            step(rand_pc(), 1'b1, 5'($urandom_range(0, 31)), rand_pc(), 1'b0, 32'h0, 1'b1, 1'b0);
            if (i == 65534) check("t6_mcount_near", 32'(MispredCount), 32'hFFFE);
        end
        check("t6_mcount_sat", 32'(MispredCount), 32'hFFFF);

        repeat (2) @(posedge CLK);
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
